// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with word-serial line refill; optional ICACHE_STATS_EN adds hit_cnt/miss_cnt outputs. Ports: clk, rst, rdy, flush, pc -> instr_valid, instr_out; mem_req, mem_addr -> mem_valid, mem_data.
module icache_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic [31:0] pc,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - OW - IW;
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int OB = OW > 0 ? OW : 1;
  localparam int IB = IW > 0 ? IW : 1;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nx;
  logic [31:0] data_mem [WAYS][SETS][LINE_WORDS];
  logic [TW-1:0] tag_mem [WAYS][SETS];
  logic [WAYS-1:0] valid [SETS];
  logic [WW-1:0] rr [SETS];
  logic [OB-1:0] off, wcnt;
  logic [IB-1:0] idx, fidx;
  logic [TW-1:0] tag, ftag;
  logic [WW-1:0] hit_way, victim, vway;
  logic [3:0] nhit;
  logic abort, miss, last;
  assign off = OB'((pc >> 2) & 32'(LINE_WORDS - 1));
  assign idx = IB'((pc >> (2 + OW)) & 32'(SETS - 1));
  assign tag = TW'(pc >> (2 + OW + IW));
  // Descending scan: the lowest-numbered invalid way ends up as victim.
  always_comb begin
    nhit = '0;
    hit_way = '0;
    victim = rr[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[idx][w] && tag_mem[w][idx] == tag) begin
        nhit = nhit + 4'd1;
        hit_way = WW'(w);
      end
      if (!valid[idx][w]) victim = WW'(w);
    end
  end
  assign instr_valid = state == IDLE && !flush && nhit == 4'd1;
  assign instr_out = data_mem[hit_way][idx][off];
  assign miss = state == IDLE && rdy && !flush && !instr_valid;
  assign last = wcnt == OB'(LINE_WORDS - 1);
  always_comb begin
    state_nx = state;
    state_nx = !rdy ? state :
               (state == IDLE && miss) ? FILL :
               (state == FILL && mem_valid && last) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req <= 1'b0;
      mem_addr <= '0;
      abort <= 1'b0;
      wcnt <= '0;
      fidx <= '0;
      ftag <= '0;
      vway <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s] <= '0;
      end
    end else if (rdy) begin
      if (flush)
        for (int s = 0; s < SETS; s++) valid[s] <= '0;
      if (miss) begin
        mem_req <= 1'b1;
        mem_addr <= pc & ~32'(LINE_WORDS * 4 - 1);
        wcnt <= '0;
        fidx <= idx;
        ftag <= tag;
        vway <= victim;
        abort <= 1'b0;
      end
      if (state == FILL && flush) abort <= 1'b1;
      if (state == FILL && mem_valid) begin
        mem_addr <= mem_addr + 32'd4;
        wcnt <= wcnt + OB'(1);
        if (last) begin
          mem_req <= 1'b0;
          // A flush anywhere in the fill (including this cycle) drops the line.
          if (!abort && !flush) begin
            valid[fidx][vway] <= 1'b1;
            rr[fidx] <= WW'((32'(rr[fidx]) + 32'd1) % WAYS);
          end
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && rdy && state == FILL && mem_valid) begin
      data_mem[vway][fidx][wcnt] <= mem_data;
      if (last) tag_mem[vway][fidx] <= ftag;
    end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else if (rdy) begin
      if (instr_valid) hit_cnt <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed self-checking bench for icache_assoc.
module tb_icache_assoc;
  logic clk = 1'b0, rst, rdy, flush, instr_valid, mem_req, mem_valid;
  logic [31:0] pc, instr_out, mem_addr, mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int n_cmp = 0, n_bad = 0;
  icache_assoc dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .pc(pc),
    .instr_valid(instr_valid), .instr_out(instr_out),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic probe(input logic [31:0] a, input bit hit);
    rdy = 1'b0;
    pc = a;
    @(negedge clk);
    chk($sformatf("hit@%h", a), {31'd0, instr_valid}, {31'd0, hit});
    if (hit) chk($sformatf("data@%h", a), instr_out, word_of(a));
  endtask
  task automatic fill(input logic [31:0] base, input bit flush_at2, input int stall, input bit exp_hit);
    rdy = 1'b0;
    pc = base;
    @(negedge clk);
    chk("cold_miss", {31'd0, instr_valid}, 32'd0);
    rdy = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 2 && flush_at2) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      if (i == 2 && stall > 0) begin
        rdy = 1'b0;
        repeat (stall) begin
          step();
          chk("stall_req", {31'd0, mem_req}, 32'd1);
          chk("stall_addr", mem_addr, base + 32'd8);
        end
        rdy = 1'b1;
      end
      chk("fill_req", {31'd0, mem_req}, 32'd1);
      chk("fill_addr", mem_addr, base + 32'(4 * i));
      chk("fill_nohit", {31'd0, instr_valid}, 32'd0);
      mem_valid = 1'b1;
      mem_data = word_of(base + 32'(4 * i));
      step();
      mem_valid = 1'b0;
    end
    chk("fill_done_req", {31'd0, mem_req}, 32'd0);
    chk("first_idle_hit", {31'd0, instr_valid}, {31'd0, exp_hit});
    rdy = 1'b0;
  endtask
  initial begin
    rst = 1'b1; rdy = 1'b0; flush = 1'b0; pc = 32'h100; mem_valid = 1'b0; mem_data = '0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    probe(32'h100, 1'b0);
    fill(32'h100, 1'b0, 0, 1'b1);
    probe(32'h108, 1'b1);
    rdy = 1'b1; pc = 32'h100; mem_valid = 1'b1; mem_data = 32'hDEADBEEF;
    step();
    mem_valid = 1'b0;
    chk("idle_mv_req", {31'd0, mem_req}, 32'd0);
    chk("idle_mv_addr", mem_addr, 32'h110);
    probe(32'h104, 1'b1);
    fill(32'h500, 1'b0, 0, 1'b1);
    probe(32'h100, 1'b1);
    probe(32'h50C, 1'b1);
    fill(32'h900, 1'b0, 0, 1'b1);
    probe(32'h100, 1'b0);
    probe(32'h504, 1'b1);
    probe(32'h908, 1'b1);
    fill(32'h200, 1'b1, 0, 1'b0);
    probe(32'h200, 1'b0);
    probe(32'h504, 1'b0);
    fill(32'h200, 1'b0, 0, 1'b1);
    probe(32'h208, 1'b1);
    fill(32'h300, 1'b0, 5, 1'b1);
    probe(32'h30C, 1'b1);
    rdy = 1'b0; pc = 32'h400;
    @(negedge clk);
    rdy = 1'b1;
    step();
    chk("rf_req", {31'd0, mem_req}, 32'd1);
    mem_valid = 1'b1; mem_data = word_of(32'h400);
    step();
    mem_valid = 1'b0; rst = 1'b1; rdy = 1'b0;
    step();
    rst = 1'b0;
    chk("rf_rst_req", {31'd0, mem_req}, 32'd0);
    chk("rf_rst_addr", mem_addr, 32'd0);
    probe(32'h400, 1'b0);
    probe(32'h200, 1'b0);
    probe(32'h300, 1'b0);
`ifdef ICACHE_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    fill(32'h100, 1'b0, 0, 1'b1);
    rdy = 1'b1; pc = 32'h100;
    repeat (3) step();
    rdy = 1'b0;
    chk("miss_cnt", miss_cnt, 32'd1);
    chk("hit_cnt", hit_cnt, 32'd3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity (power of 2, 1..8).
REQ-002 SHALL have parameter SETS, default 64, sets per way (power of 2).
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of 2, 1..16).
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port rdy  in  1  global enable; state frozen when low.
REQ-007 SHALL have port flush  in  1  invalidate-all request.
REQ-008 SHALL have port pc  in  32  fetch address; bits [1:0] ignored.
REQ-009 SHALL have port instr_valid  out  1  combinational hit indication.
REQ-010 SHALL have port instr_out  out  32  instruction at pc when hit.
REQ-011 SHALL have port mem_req  out  1  refill word request, registered.
REQ-012 SHALL have port mem_addr  out  32  word-aligned refill address, registered.
REQ-013 SHALL have port mem_valid  in  1  one-cycle pulse: mem_data is the word at mem_addr.
REQ-014 SHALL have port mem_data  in  32  refill data.

Function
REQ-015 SHALL split pc into word offset [log2(LINE_WORDS)+1:2], index (next log2(SETS) bits) and tag (remaining upper bits).
REQ-016 SHALL assert instr_valid only in IDLE with no flush, when exactly one way at the index is valid with a matching tag; instr_out SHALL then be that way's word at the offset, and is don't-care otherwise.
REQ-017 SHALL implement FSM IDLE -> FILL on a miss (IDLE, rdy=1, no flush, no hit), and FILL -> IDLE on the mem_valid for the last word.
REQ-018 SHALL, on entering FILL, latch the line base (pc with offset and byte bits cleared) and drive mem_req=1, mem_addr=base on the next cycle.
REQ-019 SHALL keep mem_req high through FILL; each mem_valid writes mem_data into the victim line at the current word and advances mem_addr by 4; mem_req SHALL fall in the cycle after the last mem_valid.
REQ-020 SHALL select the victim as the lowest-numbered invalid way, else the set's round-robin pointer; the pointer SHALL increment (mod WAYS) on each fill into that set.
REQ-021 SHALL write the tag and set the valid bit at the last word; instr_valid SHALL be 0 throughout FILL, and a re-presented pc SHALL hit on the first IDLE cycle.
REQ-022 SHALL, on flush in IDLE, clear every valid bit in one cycle.
REQ-023 SHALL, on flush in FILL, clear every valid bit, complete the outstanding word sequence, and not install the filled line.
REQ-024 SHALL ignore mem_valid in IDLE.
REQ-025 SHALL hold all state and registered outputs unchanged while rdy=0; memory SHALL not pulse mem_valid while rdy=0.

Reset
REQ-026 SHALL, on rst, enter IDLE, clear all valid bits and round-robin pointers, and drive mem_req=0, mem_addr=0.
REQ-027 SHALL, on rst mid-FILL, abandon the fill with no line installed; mem_req SHALL be 0 on the next cycle.
REQ-028 SHALL not reset the data and tag arrays.

Configuration
REQ-029 SHALL, with ICACHE_STATS_EN defined, add outputs hit_cnt and miss_cnt (32-bit, reset 0, wrapping): hit_cnt counts rdy cycles with instr_valid=1; miss_cnt counts IDLE->FILL transitions.
REQ-030 SHALL, without ICACHE_STATS_EN, omit both ports and counters, leaving behaviour otherwise identical.

Verification
REQ-031 SHALL cover: defaults, cold pc=0x100 -> mem_addr 0x100,0x104,0x108,0x10C in turn; then pc=0x108 -> instr_valid=1 with the third word returned.
REQ-032 SHALL cover: fill 0x100 then 0x500 (both index 0x10) -> both hit; fill 0x900 -> 0x100 evicted (pointer=0), 0x500 still hits.
REQ-033 SHALL cover: flush after the second mem_valid of a fill for 0x200 -> two more words are fetched, then 0x200 misses and refetches.
REQ-034 SHALL cover: rdy=0 for 5 cycles mid-fill -> mem_req/mem_addr unchanged; the fill resumes correctly.
REQ-035 SHALL cover: rst during FILL -> mem_req=0 next cycle, all lookups miss, no stale hit.
REQ-036 SHALL cover: with ICACHE_STATS_EN, 1 miss on 0x100 then 3 hit cycles -> miss_cnt=1, hit_cnt=3.
